datapath_controller: RTL and testbench
======================================

DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 The block SHALL have these ports, in order:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- s  input  1  start request; level-sensitive; sampled only in WAIT.
- opcode  input  3  instruction bits [15:13], driven by the instruction register.
- op  input  2  instruction bits [12:11], driven by the instruction register.
- nsel  output  3  one-hot register-number select: [2] = Rn, [1] = Rd, [0] = Rm; 000 when no select is needed.
- vsel  output  2  write-back source: 00 = datapath C, 10 = sximm8. Other codes are never driven.
- loada  output  1  load register A.
- loadb  output  1  load register B.
- asel  output  1  1 forces the ALU A operand to zero.
- loadc  output  1  load result register C.
- loads  output  1  load status flags N, V and Z.
- write  output  1  register-file write enable.
- w  output  1  high exactly while in WAIT.

REQ-002 Clock and reset are one clock named clk and a synchronous, active-high reset named reset.

Function
REQ-003 The FSM SHALL be Moore with states WAIT, DECODE, WRITE_IMM, GET_A, GET_B, ALU and WRITE_REG.
- All outputs decode from the state register and the latched opcode/op only.
- There are no combinational paths from s, opcode or op to any output.

REQ-004 State transitions SHALL be:
- WAIT: goes to DECODE if s=1; otherwise stays in WAIT.
- DECODE: goes to the first state for the decoded class (REQ-006).
- WRITE_IMM: goes to WAIT.
- GET_A: goes to GET_B.
- GET_B: goes to ALU.
- ALU: goes to WAIT for CMP; otherwise goes to WRITE_REG.
- WRITE_REG: goes to WAIT.

REQ-005 opcode and op SHALL be captured into internal registers on the WAIT-to-DECODE edge.
- Later changes to opcode or op have no effect until the next WAIT exit.

REQ-006 Decode SHALL use the captured {opcode,op}:
- 110_10 (MOV imm): goes to WRITE_IMM.
- 110_00 (MOV shift): goes to GET_B.
- 101_11 (MVN): goes to GET_B.
- 101_00 (ADD), 101_01 (CMP), 101_10 (AND): go to GET_A.
- Any other value: goes to WAIT with no strobes asserted (illegal instruction, silently dropped).

REQ-007 Per-state outputs SHALL be as listed below; every output not listed is 0.
- WAIT: w=1.
- WRITE_IMM: nsel=100, vsel=10, write=1.
- GET_A: nsel=100, loada=1.
- GET_B: nsel=001, loadb=1.
- ALU: loadc=1, except for CMP, which asserts loads=1 and loadc=0.
- ALU: asel=1 for MOV shift and MVN; asel=0 otherwise.
- WRITE_REG: nsel=010, vsel=00, write=1.

REQ-008 The number of cycles with w=0 per instruction SHALL be:
- MOV imm: 2.
- MOV shift: 4.
- MVN: 4.
- CMP: 4.
- ADD and AND: 5.
- Illegal instruction: 1.

REQ-009 If s is still 1 when the FSM returns to WAIT, w SHALL be high for exactly one cycle before DECODE of the next instruction.

REQ-010 write and loads SHALL never be asserted in the same cycle.
- At most one of loada, loadb, loadc, loads and write is high in any cycle.

Reset
REQ-011 reset=1 at a rising edge SHALL force the FSM to WAIT from any state, including mid-instruction.
- The captured opcode/op are cleared to 0.

REQ-012 During and after reset, the outputs SHALL be: w=1; all strobes 0; nsel=000; vsel=00.
- Reset SHALL take priority over s.

REQ-013 No register write SHALL occur in the cycle after a reset that interrupted an instruction.

Structure
REQ-014 A shared package cpu_ctrl_pkg SHALL hold:
- the state encoding (3-bit);
- the opcode/op constants (OPC_MOV=110, OPC_ALU=101, the op codes);
- the nsel one-hot constants;
- the vsel codes.

REQ-015 Opcode classification SHALL live in one combinational sub-module, ctrl_decode.
- Input: the captured {opcode,op}.
- Output: the instruction class (MOV_IMM, MOV_SH, MVN, ALU2, CMP, ILLEGAL).
- The FSM and its output decode remain in datapath_controller.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- MOV imm: reset, then s=1 with opcode=110, op=10 -> w=0 for 2 cycles; WRITE_IMM shows nsel=100, vsel=10, write=1; w returns to 1.
- ADD: opcode=101, op=00, s pulsed for 1 cycle -> sequence GET_A (nsel=100, loada), GET_B (nsel=001, loadb), ALU (loadc, asel=0), WRITE_REG (nsel=010, write); 5 cycles with w=0.
- CMP: opcode=101, op=01 -> ALU shows loads=1, loadc=0; write never asserted; back to WAIT after 4 cycles.
- MVN with opcode changed to 110_10 during GET_B -> ALU still shows asel=1 and the WRITE_REG path runs (captured-opcode check).
- reset asserted during GET_B of an AND -> next cycle WAIT, w=1, all strobes 0, no write; an illegal opcode 111_00 with s=1 -> exactly 1 cycle with w=0, no strobes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the datapath controller: state encoding, instruction
// field constants, select codes, instruction classes and the per-state output map.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_SH  = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_SH  = 3'd2,
    CLS_MVN     = 3'd3,
    CLS_ALU2    = 3'd4,
    CLS_CMP     = 3'd5
  } cls_e;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       w;
  } ctrl_out_t;

  // Output pattern shown while sitting in state st for an instruction of class cls.
  function automatic ctrl_out_t ctrl_outputs(input state_e st, input cls_e cls);
    ctrl_out_t o;
    o      = '0;
    o.nsel = NSEL_NONE;
    o.vsel = VSEL_C;
    case (st)
      S_WAIT: o.w = 1'b1;
      S_WRITE_IMM: begin
        o.nsel  = NSEL_RN;
        o.vsel  = VSEL_IMM;
        o.write = 1'b1;
      end
      S_GET_A: begin
        o.nsel  = NSEL_RN;
        o.loada = 1'b1;
      end
      S_GET_B: begin
        o.nsel  = NSEL_RM;
        o.loadb = 1'b1;
      end
      S_ALU: begin
        o.loads = (cls == CLS_CMP);
        o.loadc = (cls != CLS_CMP);
        o.asel  = (cls == CLS_MOV_SH) || (cls == CLS_MVN);
      end
      S_WRITE_REG: begin
        o.nsel  = NSEL_RD;
        o.vsel  = VSEL_C;
        o.write = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Illegal instructions fall straight back to WAIT, costing only the DECODE cycle.
  function automatic state_e first_state(input cls_e cls);
    state_e st;
    case (cls)
      CLS_MOV_IMM:       st = S_WRITE_IMM;
      CLS_MOV_SH,
      CLS_MVN:           st = S_GET_B;
      CLS_ALU2, CLS_CMP: st = S_GET_A;
      default:           st = S_WAIT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational classification of a captured {opcode,op} into an instruction class.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] instr_i,
  output cls_e       cls_o
);

  logic [2:0] opc;
  logic [1:0] op;

  assign opc = instr_i[4:2];
  assign op  = instr_i[1:0];

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (opc == OPC_MOV) begin
      if (op == OP_MOV_IMM)     cls_o = CLS_MOV_IMM;
      else if (op == OP_MOV_SH) cls_o = CLS_MOV_SH;
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  cls_o = CLS_ALU2;
        OP_AND:  cls_o = CLS_ALU2;
        OP_CMP:  cls_o = CLS_CMP;
        OP_MVN:  cls_o = CLS_MVN;
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/datapath_controller.sv
// Moore FSM sequencing the register file / ALU datapath; outputs are registered
// from the next state so they follow the state register with no input paths.
module datapath_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       w
);

  state_e    state_q, state_d;
  logic [4:0] instr_q, instr_d;
  ctrl_out_t out_q, out_d;
  cls_e      cls;

  ctrl_decode u_decode (
    .instr_i (instr_q),
    .cls_o   (cls)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          instr_d = {opcode, op};
        end
      end
      S_DECODE:    state_d = first_state(cls);
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
    // The class only changes on the WAIT->DECODE edge, where DECODE outputs are class-independent.
    out_d = ctrl_outputs(state_d, cls);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      instr_q <= '0;
      out_q   <= ctrl_outputs(S_WAIT, CLS_ILLEGAL);
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      out_q   <= out_d;
    end
  end

  assign nsel  = out_q.nsel;
  assign vsel  = out_q.vsel;
  assign loada = out_q.loada;
  assign loadb = out_q.loadb;
  assign asel  = out_q.asel;
  assign loadc = out_q.loadc;
  assign loads = out_q.loads;
  assign write = out_q.write;
  assign w     = out_q.w;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: directed instruction scenarios then randomized traffic,
// compared cycle by cycle against a per-instruction expected output trace.
module tb_datapath_controller;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, asel, loadc, loads, write, w;

  int vectors;
  int miscompares;

  // Packed view: {nsel[2:0], vsel[1:0], loada, loadb, asel, loadc, loads, write, w}
  logic [11:0] exp_q[$];
  logic [11:0] cur;

  datapath_controller dut (
    .clk    (clk),
    .reset  (reset),
    .s      (s),
    .opcode (opcode),
    .op     (op),
    .nsel   (nsel),
    .vsel   (vsel),
    .loada  (loada),
    .loadb  (loadb),
    .asel   (asel),
    .loadc  (loadc),
    .loads  (loads),
    .write  (write),
    .w      (w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic [2:0] ns, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic as_v,
                                     input logic lc, input logic ls, input logic wr,
                                     input logic wv);
    return {ns, vs, la, lb, as_v, lc, ls, wr, wv};
  endfunction

  function automatic logic [11:0] observed();
    return {nsel, vsel, loada, loadb, asel, loadc, loads, write, w};
  endfunction

  // Expected trace of one instruction, from DECODE through the return to WAIT.
  task automatic push_instr(input logic [2:0] opc_v, input logic [1:0] op_v);
    logic [11:0] idle, dec, wimm, ga, gb, alu_c, alu_a, alu_s, wreg;
    idle  = mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    dec   = mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    wimm  = mk(3'b100, 2'b10, 0, 0, 0, 0, 0, 1, 0);
    ga    = mk(3'b100, 2'b00, 1, 0, 0, 0, 0, 0, 0);
    gb    = mk(3'b001, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    alu_c = mk(3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 0);
    alu_a = mk(3'b000, 2'b00, 0, 0, 1, 1, 0, 0, 0);
    alu_s = mk(3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    wreg  = mk(3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0);
    exp_q.push_back(dec);
    case ({opc_v, op_v})
      5'b110_10: exp_q.push_back(wimm);
      5'b110_00, 5'b101_11: begin
        exp_q.push_back(gb); exp_q.push_back(alu_a); exp_q.push_back(wreg);
      end
      5'b101_00, 5'b101_10: begin
        exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(alu_c); exp_q.push_back(wreg);
      end
      5'b101_01: begin
        exp_q.push_back(ga); exp_q.push_back(gb); exp_q.push_back(alu_s);
      end
      default: ;
    endcase
    exp_q.push_back(idle);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic s_v, input logic [2:0] opc_v, input logic [1:0] op_v,
                      input logic rst_v);
    s = s_v; opcode = opc_v; op = op_v; reset = rst_v;
    @(posedge clk);
    if (rst_v) begin
      exp_q.delete();
      cur = mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else if (s_v) begin
      push_instr(opc_v, op_v);
      cur = exp_q.pop_front();
    end else begin
      cur = mk(3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    end
    #1;
    check("outputs", observed(), cur);
    vectors++;
    assert ($countones({loada, loadb, loadc, loads, write}) <= 1) else begin
      miscompares++;
      $error("FAIL strobe_onehot: observed %05b expected at most one bit",
             {loada, loadb, loadc, loads, write});
    end
  endtask

  // Issue one instruction with a 1-cycle s pulse and measure the w=0 run length.
  task automatic run_instr(input string tag, input logic [2:0] opc_v, input logic [1:0] op_v,
                           input int exp_len);
    int busy;
    busy = 0;
    step(1'b1, opc_v, op_v, 1'b0);
    for (int i = 0; i < 12 && w === 1'b0; i++) begin
      busy++;
      step(1'b0, opc_v, op_v, 1'b0);
    end
    vectors++;
    assert (busy == exp_len) else begin
      miscompares++;
      $error("FAIL %s_len: observed %0d expected %0d", tag, busy, exp_len);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    s = 0; opcode = 0; op = 0; reset = 1;
    cur = '0;

    // Reset with s held high: reset wins.
    step(1'b1, 3'b110, 2'b10, 1'b1);
    step(1'b1, 3'b110, 2'b10, 1'b1);
    check("reset_state", observed(), 12'h001);
    step(1'b0, 3'b000, 2'b00, 1'b0);

    run_instr("mov_imm", 3'b110, 2'b10, 2);
    run_instr("add",     3'b101, 2'b00, 5);
    run_instr("cmp",     3'b101, 2'b01, 4);
    run_instr("mov_sh",  3'b110, 2'b00, 4);
    run_instr("and",     3'b101, 2'b10, 5);
    run_instr("illegal", 3'b111, 2'b00, 1);

    // MVN, opcode changed to MOV imm after capture: ALU must still use MVN.
    step(1'b1, 3'b101, 2'b11, 1'b0);
    step(1'b0, 3'b110, 2'b10, 1'b0);
    step(1'b0, 3'b110, 2'b10, 1'b0);
    check("mvn_alu_asel", {11'd0, asel}, 12'd1);
    step(1'b0, 3'b110, 2'b10, 1'b0);
    check("mvn_write_reg", {nsel, 8'd0, write}, {3'b010, 8'd0, 1'b1});
    step(1'b0, 3'b110, 2'b10, 1'b0);

    // AND interrupted by reset during GET_B.
    step(1'b1, 3'b101, 2'b10, 1'b0);
    step(1'b0, 3'b101, 2'b10, 1'b0);
    step(1'b0, 3'b101, 2'b10, 1'b0);
    check("and_get_b", {nsel, 8'd0, loadb}, {3'b001, 8'd0, 1'b1});
    step(1'b0, 3'b101, 2'b10, 1'b1);
    check("reset_mid", observed(), 12'h001);
    step(1'b0, 3'b101, 2'b10, 1'b0);
    check("post_reset_nowrite", {11'd0, write}, 12'd0);

    // Back-to-back with s held high: one WAIT cycle between instructions.
    for (int i = 0; i < 10; i++) step(1'b1, 3'b110, 2'b10, 1'b0);
    step(1'b0, 3'b000, 2'b00, 1'b0);
    step(1'b0, 3'b000, 2'b00, 1'b0);

    // Randomized traffic, mostly legal instructions.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] legal [6];
      logic [4:0] ins;
      legal[0] = 5'b110_10; legal[1] = 5'b110_00; legal[2] = 5'b101_11;
      legal[3] = 5'b101_00; legal[4] = 5'b101_01; legal[5] = 5'b101_10;
      if ($urandom_range(0, 9) < 8) ins = legal[$urandom_range(0, 5)];
      else ins = 5'($urandom);
      step(($urandom_range(0, 2) == 0), ins[4:2], ins[1:0], ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
